// File: rtl/spi_shift_engine.sv
// Master-mode SPI shift engine: frames one word with programmable clock mode, bit order,
// word length, baud rate and slave select, and returns the received word.
module spi_shift_engine #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned LEN_WIDTH  = $clog2(DATA_WIDTH),
    parameter int unsigned BR_WIDTH   = 8,
    parameter int unsigned NUM_SS     = 4
) (
    input  logic                      pclk,
    input  logic                      preset_n,
    input  logic                      start,
    input  logic                      abort,
    input  logic [DATA_WIDTH-1:0]     tx_data,
    input  logic                      cpol,
    input  logic                      cpha,
    input  logic                      dord,
    input  logic [LEN_WIDTH-1:0]      datalen,
    input  logic [BR_WIDTH-1:0]       spi_br,
    input  logic [$clog2(NUM_SS)-1:0] ss_sel,
    output logic                      busy,
    output logic                      done,
    output logic [DATA_WIDTH-1:0]     rx_data,
    output logic                      sclk,
    output logic                      mosi,
    input  logic                      miso,
    output logic [NUM_SS-1:0]         ss_n
);

    localparam int unsigned SS_WIDTH = $clog2(NUM_SS);
    // Toggle counter must reach 2*DATA_WIDTH.
    localparam int unsigned TW = LEN_WIDTH + 2;

    typedef enum logic [2:0] {StIdle, StLead, StShift, StTrail, StDone} state_e;

    state_e                  state_q, state_d;
    logic [BR_WIDTH-1:0]     cnt_q, cnt_d;
    logic [TW-1:0]           tog_q, tog_d;
    logic                    cpol_q, cpol_d, cpha_q, cpha_d, dord_q, dord_d;
    logic [LEN_WIDTH-1:0]    len_q, len_d;
    logic [BR_WIDTH-1:0]     br_q, br_d;
    logic [DATA_WIDTH-1:0]   tx_q, tx_d, rx_sh_q, rx_sh_d;
    logic                    busy_q, busy_d, done_q, done_d;
    logic [DATA_WIDTH-1:0]   rx_data_q, rx_data_d;
    logic                    sclk_q, sclk_d, mosi_q, mosi_d;
    logic [NUM_SS-1:0]       ss_n_q, ss_n_d;

    logic [LEN_WIDTH-1:0]    len_in;
    logic [NUM_SS-1:0]       ss_dec;
    logic [TW-1:0]           tog_nx, two_n, half, samp_j, shift_pos, samp_pos;
    logic                    lead_edge, sample_edge, shift_valid;

    if (DATA_WIDTH == (1 << LEN_WIDTH)) begin : g_len_full
        assign len_in = datalen;
    end else begin : g_len_clamp
        localparam logic [LEN_WIDTH-1:0] MAX_LEN = LEN_WIDTH'(DATA_WIDTH - 1);
        assign len_in = (datalen > MAX_LEN) ? MAX_LEN : datalen;
    end

    // Out-of-range selects simply match no line.
    always_comb begin
        ss_dec = '1;
        for (int unsigned i = 0; i < NUM_SS; i++) begin
            if (ss_sel == SS_WIDTH'(i)) ss_dec[i] = 1'b0;
        end
    end

    // Toggle t (1-based): odd = leading edge. Shift edges drive bit t/2, sample edges
    // capture bit (t-1)/2.
    assign tog_nx      = tog_q + 1'b1;
    assign two_n       = (TW'(len_q) + TW'(1)) << 1;
    assign half        = tog_nx >> 1;
    assign lead_edge   = tog_nx[0];
    assign sample_edge = lead_edge ^ cpha_q;
    assign samp_j      = lead_edge ? half : half - TW'(1);
    assign shift_pos   = dord_q ? half : TW'(len_q) - half;
    assign samp_pos    = dord_q ? samp_j : TW'(len_q) - samp_j;
    assign shift_valid = half <= TW'(len_q);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        tog_d     = tog_q;
        cpol_d    = cpol_q;
        cpha_d    = cpha_q;
        dord_d    = dord_q;
        len_d     = len_q;
        br_d      = br_q;
        tx_d      = tx_q;
        rx_sh_d   = rx_sh_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        rx_data_d = rx_data_q;
        sclk_d    = sclk_q;
        mosi_d    = mosi_q;
        ss_n_d    = ss_n_q;

        case (state_q)
            StIdle, StDone: begin
                if (start && !abort) begin
                    state_d = StLead;
                    cnt_d   = '0;
                    tog_d   = '0;
                    cpol_d  = cpol;
                    cpha_d  = cpha;
                    dord_d  = dord;
                    len_d   = len_in;
                    br_d    = spi_br;
                    tx_d    = tx_data;
                    rx_sh_d = '0;
                    busy_d  = 1'b1;
                    sclk_d  = cpol;
                    ss_n_d  = ss_dec;
                    if (!cpha) mosi_d = tx_data[dord ? '0 : len_in];
                end else begin
                    state_d = StIdle;
                    busy_d  = 1'b0;
                    ss_n_d  = '1;
                end
            end
            StLead, StShift, StTrail: begin
                if (abort) begin
                    state_d = StIdle;
                    busy_d  = 1'b0;
                    sclk_d  = cpol_q;
                    ss_n_d  = '1;
                end else if (cnt_q != br_q) begin
                    cnt_d = cnt_q + 1'b1;
                end else begin
                    cnt_d = '0;
                    if (state_q == StTrail) begin
                        state_d   = StDone;
                        done_d    = 1'b1;
                        busy_d    = 1'b0;
                        ss_n_d    = '1;
                        rx_data_d = rx_sh_q;
                    end else begin
                        tog_d   = tog_nx;
                        sclk_d  = ~sclk_q;
                        state_d = (tog_nx == two_n) ? StTrail : StShift;
                        if (sample_edge) begin
                            rx_sh_d[samp_pos[LEN_WIDTH-1:0]] = miso;
                        end else if (shift_valid) begin
                            mosi_d = tx_q[shift_pos[LEN_WIDTH-1:0]];
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            tog_q     <= '0;
            cpol_q    <= 1'b0;
            cpha_q    <= 1'b0;
            dord_q    <= 1'b0;
            len_q     <= '0;
            br_q      <= '0;
            tx_q      <= '0;
            rx_sh_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rx_data_q <= '0;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
            ss_n_q    <= '1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            tog_q     <= tog_d;
            cpol_q    <= cpol_d;
            cpha_q    <= cpha_d;
            dord_q    <= dord_d;
            len_q     <= len_d;
            br_q      <= br_d;
            tx_q      <= tx_d;
            rx_sh_q   <= rx_sh_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            rx_data_q <= rx_data_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
            ss_n_q    <= ss_n_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign rx_data = rx_data_q;
    assign sclk    = sclk_q;
    assign mosi    = mosi_q;
    assign ss_n    = ss_n_q;

endmodule

// File: tb/tb_spi_shift_engine.sv
// Bench for spi_shift_engine: directed and random frames checked against a cycle-timing
// model derived from the frame rules (toggle k at cycle 1+kH, done at (2N+1)H+1).
module tb_spi_shift_engine;

    logic        pclk = 1'b0;
    logic        preset_n;
    logic        start, abort;
    logic [31:0] tx_data;
    logic        cpol, cpha, dord;
    logic [4:0]  datalen;
    logic [7:0]  spi_br;
    logic [1:0]  ss_sel;
    logic        busy, done, sclk, mosi, miso;
    logic [31:0] rx_data;
    logic [3:0]  ss_n;

    logic        loop_en, miso_drv;
    logic [31:0] rx_prev;
    logic        sclk_idle;
    int          checks = 0;
    int          failures = 0;

    assign miso = loop_en ? mosi : miso_drv;

    always #5 pclk = ~pclk;

    spi_shift_engine dut (
        .pclk     (pclk),
        .preset_n (preset_n),
        .start    (start),
        .abort    (abort),
        .tx_data  (tx_data),
        .cpol     (cpol),
        .cpha     (cpha),
        .dord     (dord),
        .datalen  (datalen),
        .spi_br   (spi_br),
        .ss_sel   (ss_sel),
        .busy     (busy),
        .done     (done),
        .rx_data  (rx_data),
        .sclk     (sclk),
        .mosi     (mosi),
        .miso     (miso),
        .ss_n     (ss_n)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic bit_at(input logic [31:0] v, input int i);
        logic [31:0] t;
        t = v >> i;
        return t[0];
    endfunction

    task automatic check_reset();
        chk("rst_busy", 32'(busy), 32'(1'b0));
        chk("rst_done", 32'(done), 32'(1'b0));
        chk("rst_rx_data", rx_data, 32'h0);
        chk("rst_sclk", 32'(sclk), 32'(1'b0));
        chk("rst_mosi", 32'(mosi), 32'(1'b0));
        chk("rst_ss_n", 32'(ss_n), 32'(4'hF));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge pclk); #1;
            chk("idle_busy", 32'(busy), 32'(1'b0));
            chk("idle_done", 32'(done), 32'(1'b0));
            chk("idle_ss_n", 32'(ss_n), 32'(4'hF));
            chk("idle_sclk", 32'(sclk), 32'(sclk_idle));
            chk("idle_rx_hold", rx_data, rx_prev);
        end
    endtask

    // Called at #1 after a posedge while the DUT is idle or in its done cycle.
    task automatic run_xfer(input logic p_cpol, input logic p_cpha, input logic p_dord,
                            input logic [4:0] p_len, input logic [7:0] p_br,
                            input logic [1:0] p_ss, input logic [31:0] p_tx,
                            input logic p_loop, input logic [31:0] p_miso,
                            input int p_poke, input int p_abort);
        int          n, h, last, stop_at, k, kraw, sd, j, pos;
        logic [31:0] rx_exp;
        logic [3:0]  ss_exp;
        n       = int'(p_len) + 1;
        h       = int'(p_br) + 1;
        last    = (2 * n + 1) * h + 1;
        stop_at = (p_abort > 0) ? p_abort + 1 : last;
        rx_exp  = '0;
        for (int b = 0; b < n; b++) begin
            pos    = p_dord ? b : int'(p_len) - b;
            rx_exp = rx_exp | (32'(p_loop ? bit_at(p_tx, pos) : bit_at(p_miso, b)) << pos);
        end
        ss_exp        = 4'hF;
        ss_exp[p_ss]  = 1'b0;

        cpol = p_cpol; cpha = p_cpha; dord = p_dord; datalen = p_len; spi_br = p_br;
        ss_sel = p_ss; tx_data = p_tx; loop_en = p_loop; miso_drv = p_miso[0];
        start = 1'b1;

        for (int c = 1; c <= stop_at; c++) begin
            @(posedge pclk); #1;
            if (c == 1) begin
                start   = 1'b0;
                cpol    = 1'($urandom);
                cpha    = 1'($urandom);
                dord    = 1'($urandom);
                datalen = 5'($urandom);
                spi_br  = 8'($urandom);
                ss_sel  = 2'($urandom);
                tx_data = $urandom;
            end
            if (c == p_poke) start = 1'b1;
            else if (c == p_poke + 1) start = 1'b0;
            if (p_abort > 0 && c == p_abort) abort = 1'b1;
            if (p_abort > 0 && c == p_abort + 1) begin
                abort = 1'b0;
                chk("abort_busy", 32'(busy), 32'(1'b0));
                chk("abort_done", 32'(done), 32'(1'b0));
                chk("abort_ss_n", 32'(ss_n), 32'(4'hF));
                chk("abort_sclk", 32'(sclk), 32'(p_cpol));
                chk("abort_rx_hold", rx_data, rx_prev);
                sclk_idle = p_cpol;
                return;
            end
            kraw = (c - 1) / h;
            k    = (kraw > 2 * n) ? 2 * n : kraw;
            chk("busy", 32'(busy), 32'(c < last));
            chk("done", 32'(done), 32'(c == last));
            chk("sclk", 32'(sclk), 32'(p_cpol ^ (k % 2 == 1)));
            chk("ss_n", 32'(ss_n), 32'((c < last) ? ss_exp : 4'hF));
            if ((c - 1) % h == 0 && kraw >= 1 && kraw <= 2 * n && (kraw % 2) != int'(p_cpha)) begin
                j   = (kraw - 1 - int'(p_cpha)) / 2;
                pos = p_dord ? j : int'(p_len) - j;
                chk("mosi_bit", 32'(mosi), 32'(bit_at(p_tx, pos)));
            end
            sd       = p_cpha ? k / 2 : (k + 1) / 2;
            miso_drv = (sd < n) ? bit_at(p_miso, sd) : 1'b0;
            if (c == last) chk("rx_data", rx_data, rx_exp);
            else chk("rx_hold", rx_data, rx_prev);
        end
        rx_prev   = rx_exp;
        sclk_idle = p_cpol;
    endtask

    initial begin
        preset_n = 1'b0; start = 1'b0; abort = 1'b0; tx_data = '0; cpol = 1'b0;
        cpha = 1'b0; dord = 1'b0; datalen = '0; spi_br = '0; ss_sel = '0;
        loop_en = 1'b0; miso_drv = 1'b0; rx_prev = '0; sclk_idle = 1'b0;
        #12;
        check_reset();
        @(negedge pclk); preset_n = 1'b1;
        @(posedge pclk); #1;

        // Mode 0, MSB first, loopback
        run_xfer(1'b0, 1'b0, 1'b0, 5'd7, 8'd0, 2'd0, 32'hA5, 1'b1, 32'h0, 0, 0);
        idle(2);
        // Mode 3, LSB first, miso 1,1,0,0
        run_xfer(1'b1, 1'b1, 1'b1, 5'd3, 8'd2, 2'd1, 32'h6, 1'b0, 32'h3, 0, 0);
        idle(2);
        // Full width loopback
        run_xfer(1'b0, 1'b0, 1'b0, 5'd31, 8'd0, 2'd2, 32'hDEADBEEF, 1'b1, 32'h0, 0, 0);
        idle(2);
        // Abort a 16-bit frame during cycle 10
        run_xfer(1'b1, 1'b0, 1'b0, 5'd15, 8'd0, 2'd0, 32'h1234, 1'b1, 32'h0, 0, 10);
        idle(3);
        // Ignored start at cycle 5, then back-to-back start in the done cycle
        run_xfer(1'b0, 1'b1, 1'b0, 5'd7, 8'd1, 2'd3, 32'h3C, 1'b1, 32'h0, 5, 0);
        run_xfer(1'b0, 1'b0, 1'b1, 5'd4, 8'd0, 2'd3, 32'h15, 1'b0, 32'h0A, 0, 0);
        idle(2);
        // Abort together with start in idle: abort wins
        start = 1'b1; abort = 1'b1;
        @(posedge pclk); #1;
        start = 1'b0; abort = 1'b0;
        chk("abort_start_busy", 32'(busy), 32'(1'b0));
        chk("abort_start_ss_n", 32'(ss_n), 32'(4'hF));
        idle(2);

        // Random frames, sometimes chained back to back
        for (int r = 0; r < 10; r++) begin
            run_xfer(1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom),
                     8'($urandom_range(0, 3)), 2'($urandom), $urandom, 1'($urandom),
                     $urandom, 0, 0);
            if ($urandom_range(0, 1) == 1) idle(1);
        end
        idle(1);

        // Reset asserted mid-frame between clock edges
        cpol = 1'b1; cpha = 1'b0; dord = 1'b0; datalen = 5'd15; spi_br = 8'd1;
        ss_sel = 2'd2; tx_data = 32'hFFFF; loop_en = 1'b1; start = 1'b1;
        @(posedge pclk); #1;
        start = 1'b0;
        repeat (8) @(posedge pclk);
        #3;
        preset_n = 1'b0;
        #1;
        check_reset();
        @(posedge pclk); #1;
        check_reset();
        @(negedge pclk); preset_n = 1'b1;
        @(posedge pclk); #1;
        rx_prev = '0; sclk_idle = 1'b0;
        run_xfer(1'b0, 1'b0, 1'b0, 5'd7, 8'd0, 2'd1, 32'h5A, 1'b1, 32'h0, 0, 0);
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_shift_engine.md
# spi_shift_engine

Parametrised master-mode SPI serial engine for the SPI APB peripheral. It sits between the register/control block and the pads. It accepts one word from the transmit path plus a per-transfer configuration (CPOL, CPHA, bit order, data length, baud divider, slave select), generates SCLK/MOSI/SS_n, and returns the received word with a completion pulse. It generalises the fixed 32-bit datapath with multi-slave select, an abort, and a configurable word width.

## Interface
Parameters:
- DATA_WIDTH, 32, maximum word width in bits
- LEN_WIDTH, $clog2(DATA_WIDTH), width of datalen
- BR_WIDTH, 8, width of baud divider
- NUM_SS, 4, number of slave-select outputs (≥2)

Ports:
- pclk  in  1  system clock; all logic on rising edge
- preset_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle transfer request; honoured only when busy=0
- abort  in  1  synchronous abort of the current transfer
- tx_data  in  DATA_WIDTH  word to transmit, right-aligned
- cpol  in  1  SCLK idle level
- cpha  in  1  0: sample on leading edge; 1: sample on trailing edge
- dord  in  1  0: MSB first; 1: LSB first
- datalen  in  LEN_WIDTH  bits per word minus 1
- spi_br  in  BR_WIDTH  SCLK half-period = spi_br+1 pclk cycles
- ss_sel  in  $clog2(NUM_SS)  slave to select
- busy  out  1  transfer in progress
- done  out  1  one-cycle completion pulse
- rx_data  out  DATA_WIDTH  received word, right-aligned, upper bits zero
- sclk  out  1  serial clock
- mosi  out  1  serial data out
- miso  in  1  serial data in, assumed synchronous to pclk
- ss_n  out  NUM_SS  active-low slave selects

## Operation
- Registered outputs with reset values: busy=0, done=0, rx_data=0, sclk=0, mosi=0, ss_n=all 1.
- FSM states: IDLE, LEAD, SHIFT, TRAIL, DONE.
- IDLE → LEAD on start: latch all config and tx_data. Later changes to the inputs have no effect on the transfer. The transfer uses the latched cpol throughout.
- datalen above DATA_WIDTH-1 clamps to DATA_WIDTH-1. Define N = datalen+1 and H = spi_br+1.
- ss_sel ≥ NUM_SS: no ss_n line asserts; the transfer still runs.
- LEAD: ss_n[ss_sel]=0 and sclk=cpol. The half-period counter runs for H cycles. If cpha=0, mosi drives the first bit on entry to LEAD.
- SHIFT: sclk toggles every H cycles, for 2N toggles in total. Odd toggles are leading edges; even toggles are trailing edges.
  - Sampling edge: leading if cpha=0, trailing if cpha=1.
  - Shifting edge: the other edge.
  - If cpha=1, the first bit is driven on the first leading edge. A shifting edge after the last bit leaves mosi unchanged.
- Bit order:
  - dord=0: transmit tx_data[datalen] down to [0]. The first received bit lands at rx bit datalen.
  - dord=1: transmit tx_data[0] up to [datalen]. The first received bit lands at bit 0.
- TRAIL: sclk=cpol. Hold ss_n asserted for H cycles.
- DONE: one cycle. done=1, busy=0, ss_n=all 1, and rx_data updates in this cycle. Then go to IDLE.
- rx_data holds its value until the next DONE.
- start while busy=1 is ignored.
- start in the DONE cycle is accepted: the next transfer's LEAD begins on the following cycle.
- abort in LEAD/SHIFT/TRAIL: next cycle go to IDLE with busy=0, sclk=cpol, ss_n=all 1. No done pulse; rx_data is unchanged.
- abort and start together in IDLE: abort wins and start is dropped.
- Reset asserted mid-transfer: all outputs go to reset values immediately (asynchronous).

## Timing
- Take start high in cycle 0 (IDLE).
  - busy=1 in cycles 1..(2N+1)H.
  - SCLK toggle k (k=1..2N) occurs in cycle 1+kH.
  - done=1 in cycle (2N+1)H+1.
- Latency from start to done = (2N+1)H+1 cycles.
- miso is captured on the pclk edge that produces the sampling toggle of sclk.
- mosi changes on the same pclk edge as the shifting toggle. It never changes on a sampling toggle.
- A back-to-back transfer started in the DONE cycle shows ss_n high for exactly 1 cycle between frames.

## Test plan
- Mode 0, MSB first: cpol=0, cpha=0, dord=0, datalen=7, spi_br=0, tx_data=0xA5, miso looped to mosi → mosi sequence 1,0,1,0,0,1,0,1; done at cycle 18; rx_data=0x000000A5; ss_n=4'b1110 for cycles 1..17.
- Mode 3, LSB first: cpol=1, cpha=1, dord=1, datalen=3, spi_br=2, tx_data=0x6, miso driven 1,1,0,0 → sclk idles 1 with 8 toggles 3 cycles apart; done at cycle 28; rx_data=0x3.
- Full width: datalen=31, spi_br=0, tx_data=0xDEADBEEF, loopback → rx_data=0xDEADBEEF, done at cycle 66.
- Abort: start a 16-bit transfer and assert abort at cycle 10 → cycle 11 has busy=0, ss_n=all 1, sclk=cpol; no done pulse; rx_data keeps its previous value.
- Back-to-back and ignored start: pulse start again at cycle 5 (ignored), then in the DONE cycle → exactly two transfers; ss_n high for 1 cycle between them; ss_sel=3 selects ss_n=4'b0111.
- Reset mid-transfer: deassert preset_n during SHIFT → all outputs at reset values asynchronously; after release, the FSM is in IDLE and accepts a new start.
